// File: rtl/ucode_arb.sv
// ----------------------------------------------------------------------------
// ucode_arb
//
// Purpose:
//   Arbitrates a single-port microcode memory between port A (CPU) and port B
//   (host loader). Requests are acknowledged combinationally; a round-robin
//   pointer breaks ties. Port B may hold the bus (i_b_lock) after one of its
//   grants, starving port A until the lock is released. Read data returns one
//   cycle after the acknowledge. A saturating counter records contended cycles.
//
// Ports:
//   i_clk, i_rst_n                         clock, synchronous active-low reset
//   i_a_req/i_a_wr/i_a_addr/i_a_wdata      port A command (held until ack)
//   o_a_ack, o_a_rvalid, o_a_rdata         port A accept / read return
//   i_b_req/i_b_wr/i_b_addr/i_b_wdata      port B command (held until ack)
//   i_b_lock                               port B bus-hold request
//   o_b_ack, o_b_rvalid, o_b_rdata         port B accept / read return
//   o_mem_wr, o_mem_addr, o_mem_wdata      memory command (zero when idle)
//   i_mem_rdata                            memory read data, one cycle latency
//   o_conflicts                            saturating contended-cycle count
// ----------------------------------------------------------------------------
module ucode_arb #(
  parameter int DATA_SZ = 16,
  parameter int ADDR_SZ = 10
) (
  input  logic               i_clk,
  input  logic               i_rst_n,

  input  logic               i_a_req,
  input  logic               i_a_wr,
  input  logic [ADDR_SZ-1:0] i_a_addr,
  input  logic [DATA_SZ-1:0] i_a_wdata,
  output logic               o_a_ack,
  output logic               o_a_rvalid,
  output logic [DATA_SZ-1:0] o_a_rdata,

  input  logic               i_b_req,
  input  logic               i_b_wr,
  input  logic [ADDR_SZ-1:0] i_b_addr,
  input  logic [DATA_SZ-1:0] i_b_wdata,
  input  logic               i_b_lock,
  output logic               o_b_ack,
  output logic               o_b_rvalid,
  output logic [DATA_SZ-1:0] o_b_rdata,

  output logic               o_mem_wr,
  output logic [ADDR_SZ-1:0] o_mem_addr,
  output logic [DATA_SZ-1:0] o_mem_wdata,
  input  logic [DATA_SZ-1:0] i_mem_rdata,

  output logic [7:0]         o_conflicts
);

  typedef enum logic {
    RR     = 1'b0,
    LOCK_B = 1'b1
  } state_t;

  localparam logic [7:0] CONF_MAX = 8'hFF;

  state_t       r_state;
  state_t       w_nextState;

  // 1 = port B was granted most recently, so A wins the next tie.
  logic         r_lastGrantB;

  logic         w_grantA;
  logic         w_grantB;
  logic         w_contended;

  logic         r_pendA;
  logic         r_pendB;
  logic [7:0]   r_conflicts;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= RR;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. Lock is entered only on a B grant made while in RR,
  // and left as soon as i_b_lock is seen low at an edge.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      RR: begin
        if (w_grantB && i_b_lock) begin
          w_nextState = LOCK_B;
        end
      end
      LOCK_B: begin
        if (!i_b_lock) begin
          w_nextState = RR;
        end
      end
      default: w_nextState = RR;
    endcase
  end

  // Output (grant) logic. Grants are suppressed while reset is asserted so
  // that no command reaches memory during reset.
  always_comb begin
    w_grantA = 1'b0;
    w_grantB = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        RR: begin
          if (i_a_req && i_b_req) begin
            w_grantA = r_lastGrantB;
            w_grantB = !r_lastGrantB;
          end else begin
            w_grantA = i_a_req;
            w_grantB = i_b_req;
          end
        end
        LOCK_B: begin
          w_grantB = i_b_req;
        end
        default: begin
          w_grantA = 1'b0;
          w_grantB = 1'b0;
        end
      endcase
    end
  end

  assign o_a_ack = w_grantA;
  assign o_b_ack = w_grantB;

  // Last-grant pointer. Leaving LOCK_B always hands the next tie to A.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_lastGrantB <= 1'b1;
    end else if (r_state == LOCK_B && !i_b_lock) begin
      r_lastGrantB <= 1'b1;
    end else if (w_grantA) begin
      r_lastGrantB <= 1'b0;
    end else if (w_grantB) begin
      r_lastGrantB <= 1'b1;
    end
  end

  // Memory command mux: granted port's command, all zeros when idle.
  always_comb begin
    o_mem_wr    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    if (w_grantA) begin
      o_mem_wr    = i_a_wr;
      o_mem_addr  = i_a_addr;
      o_mem_wdata = i_a_wdata;
    end else if (w_grantB) begin
      o_mem_wr    = i_b_wr;
      o_mem_addr  = i_b_addr;
      o_mem_wdata = i_b_wdata;
    end
  end

  // Pending read returns: one cycle after a read grant.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_pendA <= 1'b0;
      r_pendB <= 1'b0;
    end else begin
      r_pendA <= w_grantA && !i_a_wr;
      r_pendB <= w_grantB && !i_b_wr;
    end
  end

  // A read granted just before reset must not surface while reset is held,
  // so the valid flags are qualified by the live reset input.
  assign o_a_rvalid = r_pendA && i_rst_n;
  assign o_b_rvalid = r_pendB && i_rst_n;
  assign o_a_rdata  = o_a_rvalid ? i_mem_rdata : '0;
  assign o_b_rdata  = o_b_rvalid ? i_mem_rdata : '0;

  // Contention: both requesting outside lock, or A requesting while locked.
  assign w_contended = i_a_req && ((r_state == RR && i_b_req) || (r_state == LOCK_B));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_conflicts <= 8'd0;
    end else if (w_contended && r_conflicts != CONF_MAX) begin
      r_conflicts <= r_conflicts + 8'd1;
    end
  end

  assign o_conflicts = r_conflicts;

endmodule

// File: tb/tb_ucode_arb.sv
// ----------------------------------------------------------------------------
// tb_ucode_arb
//
// Purpose:
//   Self-checking bench for ucode_arb. A behavioural model (grant rules, a
//   shadow memory and a saturating counter) predicts every output each cycle;
//   directed scenarios pin the model with literal expectations, then random
//   traffic with random locking and occasional resets is compared to it.
// ----------------------------------------------------------------------------
module tb_ucode_arb;

  logic        clock = 1'b0;
  logic        rstN = 1'b0;
  logic        aReq = 1'b0, aWr = 1'b0;
  logic [9:0]  aAddr = '0;
  logic [15:0] aWdata = '0;
  logic        bReq = 1'b0, bWr = 1'b0, bLock = 1'b0;
  logic [9:0]  bAddr = '0;
  logic [15:0] bWdata = '0;
  logic        aAck, aRvalid, bAck, bRvalid, memWr;
  logic [15:0] aRdata, bRdata, memWdata;
  logic [15:0] memRdata = '0;
  logic [9:0]  memAddr;
  logic [7:0]  conflicts;

  int testCount = 0;
  int failCount = 0;

  // Environment memory (driven by the DUT) and the model's shadow copy.
  logic [15:0] memArr   [0:1023];
  logic [15:0] modelMem [0:1023];

  // Model state.
  bit          mLocked = 1'b0;
  bit          mLastB  = 1'b1;
  int          mConf   = 0;
  bit          mPendA  = 1'b0, mPendB = 1'b0;
  logic [15:0] mDataA  = '0, mDataB = '0;

  // DUT values captured at the last check, for literal expectations.
  logic        capAckA, capAckB, capRvA, capRvB;
  logic [15:0] capRdA, capRdB;
  logic [7:0]  capConf;

  ucode_arb #(.DATA_SZ(16), .ADDR_SZ(10)) dut (
    .i_clk(clock), .i_rst_n(rstN),
    .i_a_req(aReq), .i_a_wr(aWr), .i_a_addr(aAddr), .i_a_wdata(aWdata),
    .o_a_ack(aAck), .o_a_rvalid(aRvalid), .o_a_rdata(aRdata),
    .i_b_req(bReq), .i_b_wr(bWr), .i_b_addr(bAddr), .i_b_wdata(bWdata),
    .i_b_lock(bLock),
    .o_b_ack(bAck), .o_b_rvalid(bRvalid), .o_b_rdata(bRdata),
    .o_mem_wr(memWr), .o_mem_addr(memAddr), .o_mem_wdata(memWdata),
    .i_mem_rdata(memRdata),
    .o_conflicts(conflicts)
  );

  always #5 clock = ~clock;

  // Synchronous single-port memory, one cycle read latency.
  always @(posedge clock) begin
    if (memWr) memArr[memAddr] <= memWdata;
    memRdata <= memArr[memAddr];
  end

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Called mid-cycle: predict this cycle's outputs, compare, then advance the
  // model to the state it must hold after the coming clock edge.
  task automatic checkOutput();
    bit          gA, gB;
    bit          eWr;
    logic [9:0]  eAddr;
    logic [15:0] eWdata;
    bit          eRvA, eRvB;
    gA = 0; gB = 0;
    if (rstN) begin
      if (mLocked) gB = bReq;
      else if (aReq && bReq) begin gA = mLastB; gB = !mLastB; end
      else begin gA = aReq; gB = bReq; end
    end
    eWr = 0; eAddr = '0; eWdata = '0;
    if (gA) begin eWr = aWr; eAddr = aAddr; eWdata = aWdata; end
    if (gB) begin eWr = bWr; eAddr = bAddr; eWdata = bWdata; end
    eRvA = rstN && mPendA;
    eRvB = rstN && mPendB;

    capAckA = aAck; capAckB = bAck; capRvA = aRvalid; capRvB = bRvalid;
    capRdA = aRdata; capRdB = bRdata; capConf = conflicts;

    checkVal("ackA", aAck, gA);
    checkVal("ackB", bAck, gB);
    checkVal("memWr", memWr, eWr);
    checkVal("memAddr", memAddr, eAddr);
    checkVal("memWdata", memWdata, eWdata);
    checkVal("rvalidA", aRvalid, eRvA);
    checkVal("rvalidB", bRvalid, eRvB);
    checkVal("rdataA", aRdata, eRvA ? mDataA : 16'h0);
    checkVal("rdataB", bRdata, eRvB ? mDataB : 16'h0);
    checkVal("conflicts", conflicts, mConf);

    if (!rstN) begin
      mLocked = 0; mLastB = 1; mConf = 0; mPendA = 0; mPendB = 0;
    end else begin
      if ((!mLocked && aReq && bReq) || (mLocked && aReq))
        mConf = (mConf < 255) ? mConf + 1 : 255;
      mPendA = gA && !aWr;
      mPendB = gB && !bWr;
      if (gA) begin
        mLastB = 0;
        mDataA = modelMem[aAddr];
        if (aWr) modelMem[aAddr] = aWdata;
      end
      if (gB) begin
        mLastB = 1;
        mDataB = modelMem[bAddr];
        if (bWr) modelMem[bAddr] = bWdata;
      end
      if (mLocked) begin
        if (!bLock) begin mLocked = 0; mLastB = 1; end
      end else if (gB && bLock) begin
        mLocked = 1;
      end
    end
  endtask

  task automatic tick();
    @(negedge clock);
    checkOutput();
    @(posedge clock);
    #1;
  endtask

  task automatic clearReqs();
    aReq = 0; aWr = 0; aAddr = '0; aWdata = '0;
    bReq = 0; bWr = 0; bAddr = '0; bWdata = '0; bLock = 0;
  endtask

  task automatic doReset();
    clearReqs();
    rstN = 0;
    tick();
    tick();
    rstN = 1;
  endtask

  function automatic logic [9:0] randAddr();
    if ($urandom_range(0, 9) == 0) return 10'h3FF;
    return 10'($urandom_range(0, 15));
  endfunction

  // Random requesters: a command is held until acked, then replaced.
  task automatic applyStimulus();
    rstN = ($urandom_range(0, 199) != 0);
    if (!aReq || capAckA) begin
      aReq = ($urandom_range(0, 99) < 60);
      aWr = aReq && ($urandom_range(0, 2) == 0);
      aAddr = aReq ? randAddr() : 10'h0;
      aWdata = aReq ? 16'($urandom) : 16'h0;
    end
    if (!bReq || capAckB) begin
      bReq = ($urandom_range(0, 99) < 60);
      bWr = bReq && ($urandom_range(0, 2) == 0);
      bAddr = bReq ? randAddr() : 10'h0;
      bWdata = bReq ? 16'($urandom) : 16'h0;
    end
    if ($urandom_range(0, 9) == 0) bLock = !bLock;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      memArr[i] = 16'($urandom);
      modelMem[i] = memArr[i];
    end
    memArr[10'h010] = 16'h1234;
    modelMem[10'h010] = 16'h1234;
    clearReqs();
    rstN = 0;
    #1;

    // Reset, then a lone A read of 0x010.
    doReset();
    checkVal("lit_resetConf", capConf, 8'd0);
    checkVal("lit_resetAckA", capAckA, 1'b0);
    aReq = 1; aAddr = 10'h010;
    tick();
    checkVal("lit_readAckA", capAckA, 1'b1);
    aReq = 0; aAddr = '0;
    tick();
    checkVal("lit_readRvA", capRvA, 1'b1);
    checkVal("lit_readRdA", capRdA, 16'h1234);
    checkVal("lit_readConf", capConf, 8'd0);

    // Both ports read every cycle for six cycles: strict alternation from A.
    doReset();
    aReq = 1; aAddr = 10'h001; bReq = 1; bAddr = 10'h002;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkVal("lit_tieAckA", capAckA, (i % 2) == 0);
      checkVal("lit_tieAckB", capAckB, (i % 2) == 1);
    end
    clearReqs();
    tick();
    checkVal("lit_tieConf", capConf, 8'd6);

    // B write with lock, A stalls through the lock, B reads back, A resumes.
    doReset();
    bReq = 1; bWr = 1; bAddr = 10'h3FF; bWdata = 16'hBEEF; bLock = 1;
    tick();
    checkVal("lit_lockAckB", capAckB, 1'b1);
    bReq = 0; bWr = 0; bAddr = '0; bWdata = '0;
    aReq = 1; aAddr = 10'h005;
    tick();
    checkVal("lit_lockStallA1", capAckA, 1'b0);
    tick();
    checkVal("lit_lockStallA2", capAckA, 1'b0);
    bReq = 1; bAddr = 10'h3FF;
    tick();
    checkVal("lit_lockReadAckB", capAckB, 1'b1);
    checkVal("lit_lockStallA3", capAckA, 1'b0);
    bReq = 0; bAddr = '0; bLock = 0;
    tick();
    checkVal("lit_lockRvB", capRvB, 1'b1);
    checkVal("lit_lockRdB", capRdB, 16'hBEEF);
    checkVal("lit_lockStallA4", capAckA, 1'b0);
    tick();
    checkVal("lit_releaseAckA", capAckA, 1'b1);
    checkVal("lit_lockConf", capConf, 8'd4);
    clearReqs();
    tick();

    // Hold both requests for 300 cycles: counter saturates at 255.
    doReset();
    aReq = 1; aAddr = 10'h003; bReq = 1; bAddr = 10'h004;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (i == 10) checkVal("lit_satConf10", capConf, 8'd9);
    end
    checkVal("lit_satConf300", capConf, 8'd255);
    tick();
    checkVal("lit_satNoWrap", capConf, 8'd255);

    // Reset the cycle after an A read ack: no rvalid, next tie goes to A.
    clearReqs();
    aReq = 1; aAddr = 10'h007;
    tick();
    checkVal("lit_preRstAckA", capAckA, 1'b1);
    clearReqs();
    rstN = 0;
    tick();
    checkVal("lit_rstRvA", capRvA, 1'b0);
    rstN = 1;
    aReq = 1; aAddr = 10'h008; bReq = 1; bAddr = 10'h009;
    tick();
    checkVal("lit_postRstAckA", capAckA, 1'b1);
    checkVal("lit_postRstRvA", capRvA, 1'b0);
    clearReqs();
    tick();

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      applyStimulus();
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
